axi_iw_txn_throttle: RTL and testbench



---
 rtl/axi_iw_pkg.sv | 22 ++
 rtl/axi_iw_txn_table.sv | 128 ++++++++++++
 rtl/axi_iw_txn_throttle.sv | 118 +++++++++++
 tb/tb_axi_iw_txn_throttle.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_iw_pkg.sv
// Shared types for the AXI ID-width transaction throttle: the drain FSM
// state encoding and the layout of one ID-tracking table entry.
package axi_iw_pkg;

   // Entry fields are sized for the widest supported configuration; the
   // table zero-extends narrower IDs and counts into them.
   localparam int unsigned ENTRY_ID_W  = 16;
   localparam int unsigned ENTRY_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } thr_state_e;

   typedef struct packed {
      logic                   valid;
      logic [ENTRY_ID_W-1:0]  id;
      logic [ENTRY_CNT_W-1:0] cnt;
   } txn_entry_t;

endpackage

// File: rtl/axi_iw_txn_table.sv
// One direction of outstanding-transaction tracking: a small table of
// {valid, id, cnt} entries plus a total counter. Produces the combinational
// allow for the ID currently presented and applies issue/retire updates.
module axi_iw_txn_table
   import axi_iw_pkg::*;
#(
   parameter  int unsigned IdWidth      = 4,
   parameter  int unsigned MaxUniqIds   = 4,
   parameter  int unsigned MaxTxnsPerId = 4,
   parameter  int unsigned MaxTxns      = 8,
   localparam int unsigned TotW         = $clog2(MaxTxns + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               run_i,
   input  logic [IdWidth-1:0] req_id_i,
   input  logic               issue_i,
   input  logic               retire_i,
   input  logic [IdWidth-1:0] retire_id_i,
   output logic               allow_o,
   output logic [TotW-1:0]    tot_o
);

   localparam int unsigned IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;

   txn_entry_t            entry_reg  [MaxUniqIds];
   txn_entry_t            entry_next [MaxUniqIds];
   logic [TotW-1:0]       tot_reg;
   logic [TotW-1:0]       tot_next;

   logic [ENTRY_ID_W-1:0] req_id_ext;
   logic [ENTRY_ID_W-1:0] ret_id_ext;
   logic                  req_hit;
   logic                  free_any;
   logic                  ret_hit;
   logic [IdxW-1:0]       req_idx;
   logic [IdxW-1:0]       free_idx;
   logic [IdxW-1:0]       ret_idx;
   logic                  issue_fire;
   logic                  ret_fire;
   logic [MaxUniqIds-1:0] inc_vec;
   logic [MaxUniqIds-1:0] dec_vec;

   assign req_id_ext = ENTRY_ID_W'(req_id_i);
   assign ret_id_ext = ENTRY_ID_W'(retire_id_i);

   // Table lookups; scanning downwards leaves the lowest matching index.
   always_comb begin
      req_hit  = 1'b0;
      req_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      ret_hit  = 1'b0;
      ret_idx  = '0;
      for (int i = int'(MaxUniqIds) - 1; i >= 0; i--) begin
         if (entry_reg[i].valid && entry_reg[i].id == req_id_ext) begin
            req_hit = 1'b1;
            req_idx = IdxW'(i);
         end
         if (!entry_reg[i].valid) begin
            free_any = 1'b1;
            free_idx = IdxW'(i);
         end
         if (entry_reg[i].valid && entry_reg[i].cnt != '0 && entry_reg[i].id == ret_id_ext) begin
            ret_hit = 1'b1;
            ret_idx = IdxW'(i);
         end
      end
   end

   // Allow uses only registered table state and the presented ID.
   assign allow_o = run_i && (tot_reg < TotW'(MaxTxns)) &&
                    (req_hit ? (entry_reg[req_idx].cnt < ENTRY_CNT_W'(MaxTxnsPerId)) : free_any);

   assign issue_fire = issue_i && allow_o;
   // A retire with no live entry is dropped, which also keeps tot from underflowing.
   assign ret_fire   = retire_i && ret_hit;
   assign tot_o      = tot_reg;

   // Per-entry increment/decrement selects; a new ID takes the lowest free slot.
   genvar gi;
   for (gi = 0; gi < MaxUniqIds; gi++) begin : g_sel
      assign inc_vec[gi] = issue_fire &&
                           (req_hit ? (req_idx == IdxW'(gi)) : (free_idx == IdxW'(gi)));
      assign dec_vec[gi] = ret_fire && (ret_idx == IdxW'(gi));
   end

   // Next table contents; simultaneous issue and retire on one entry cancel out.
   always_comb begin
      entry_next = entry_reg;
      tot_next   = tot_reg;
      for (int i = 0; i < int'(MaxUniqIds); i++) begin
         if (inc_vec[i] && !dec_vec[i]) begin
            if (entry_reg[i].valid) begin
               entry_next[i].cnt = entry_reg[i].cnt + 1'b1;
            end else begin
               entry_next[i].valid = 1'b1;
               entry_next[i].id    = req_id_ext;
               entry_next[i].cnt   = ENTRY_CNT_W'(1);
            end
         end else if (dec_vec[i] && !inc_vec[i]) begin
            entry_next[i].cnt = entry_reg[i].cnt - 1'b1;
            if (entry_reg[i].cnt == ENTRY_CNT_W'(1)) begin
               entry_next[i].valid = 1'b0;
            end
         end
      end
      if (issue_fire && !ret_fire) begin
         tot_next = tot_reg + 1'b1;
      end else if (ret_fire && !issue_fire && tot_reg != '0) begin
         tot_next = tot_reg - 1'b1;
      end
   end

   // Table and total register; reset discards all tracking.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(MaxUniqIds); i++) begin
            entry_reg[i] <= '0;
         end
         tot_reg <= '0;
      end else begin
         entry_reg <= entry_next;
         tot_reg   <= tot_next;
      end
   end

endmodule

// File: rtl/axi_iw_txn_throttle.sv
// Throttles AW/AR issue so that the downstream ID-width converter never sees
// more distinct IDs, per-ID or total transactions than it can remap. A drain
// FSM can stop new requests and report idle once everything has retired.
module axi_iw_txn_throttle
   import axi_iw_pkg::*;
#(
   parameter  int unsigned IdWidth      = 4,
   parameter  int unsigned MaxUniqIds   = 4,
   parameter  int unsigned MaxTxnsPerId = 4,
   parameter  int unsigned MaxTxns      = 8,
   localparam int unsigned CntW         = $clog2(MaxTxns + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IdWidth-1:0] slv_aw_id_i,
   input  logic               slv_aw_valid_i,
   output logic               slv_aw_ready_o,
   output logic               mst_aw_valid_o,
   input  logic               mst_aw_ready_i,
   input  logic [IdWidth-1:0] mst_b_id_i,
   input  logic               mst_b_valid_i,
   input  logic               mst_b_ready_i,
   input  logic [IdWidth-1:0] slv_ar_id_i,
   input  logic               slv_ar_valid_i,
   output logic               slv_ar_ready_o,
   output logic               mst_ar_valid_o,
   input  logic               mst_ar_ready_i,
   input  logic [IdWidth-1:0] mst_r_id_i,
   input  logic               mst_r_last_i,
   input  logic               mst_r_valid_i,
   input  logic               mst_r_ready_i,
   input  logic               drain_i,
   output logic               idle_o,
   output logic [CntW-1:0]    w_outstanding_o,
   output logic [CntW-1:0]    r_outstanding_o
);

   thr_state_e state_reg;
   thr_state_e state_next;
   logic       run;
   logic       aw_allow;
   logic       ar_allow;

   assign run = (state_reg == ST_RUN);

   // Handshake gating adds no latency: both sides see the same allow.
   assign mst_aw_valid_o = slv_aw_valid_i & aw_allow;
   assign slv_aw_ready_o = mst_aw_ready_i & aw_allow;
   assign mst_ar_valid_o = slv_ar_valid_i & ar_allow;
   assign slv_ar_ready_o = mst_ar_ready_i & ar_allow;

   axi_iw_txn_table #(
      .IdWidth     (IdWidth),
      .MaxUniqIds  (MaxUniqIds),
      .MaxTxnsPerId(MaxTxnsPerId),
      .MaxTxns     (MaxTxns)
   ) u_w_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .run_i      (run),
      .req_id_i   (slv_aw_id_i),
      .issue_i    (mst_aw_valid_o & mst_aw_ready_i),
      .retire_i   (mst_b_valid_i & mst_b_ready_i),
      .retire_id_i(mst_b_id_i),
      .allow_o    (aw_allow),
      .tot_o      (w_outstanding_o)
   );

   axi_iw_txn_table #(
      .IdWidth     (IdWidth),
      .MaxUniqIds  (MaxUniqIds),
      .MaxTxnsPerId(MaxTxnsPerId),
      .MaxTxns     (MaxTxns)
   ) u_r_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .run_i      (run),
      .req_id_i   (slv_ar_id_i),
      .issue_i    (mst_ar_valid_o & mst_ar_ready_i),
      .retire_i   (mst_r_valid_i & mst_r_ready_i & mst_r_last_i),
      .retire_id_i(mst_r_id_i),
      .allow_o    (ar_allow),
      .tot_o      (r_outstanding_o)
   );

   // Drain FSM next state; a dropped drain request always returns to RUN.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_RUN: begin
            if (drain_i) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_i) begin
               state_next = ST_RUN;
            end else if (w_outstanding_o == '0 && r_outstanding_o == '0) begin
               state_next = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (!drain_i) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   // State register; idle is decoded straight from it so it is registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   assign idle_o = (state_reg == ST_DRAINED);

endmodule

// File: tb/tb_axi_iw_txn_throttle.sv
// Directed bench for axi_iw_txn_throttle. Each driven cycle queues the
// expected ready/valid/idle/count snapshot; a monitor on the falling edge
// pops and compares it against the DUT.
module tb_axi_iw_txn_throttle;

   localparam int unsigned CntW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      slv_aw_id_i = '0;
   logic            slv_aw_valid_i = 1'b0;
   logic            slv_aw_ready_o;
   logic            mst_aw_valid_o;
   logic            mst_aw_ready_i = 1'b1;
   logic [3:0]      mst_b_id_i = '0;
   logic            mst_b_valid_i = 1'b0;
   logic            mst_b_ready_i = 1'b1;
   logic [3:0]      slv_ar_id_i = '0;
   logic            slv_ar_valid_i = 1'b0;
   logic            slv_ar_ready_o;
   logic            mst_ar_valid_o;
   logic            mst_ar_ready_i = 1'b1;
   logic [3:0]      mst_r_id_i = '0;
   logic            mst_r_last_i = 1'b0;
   logic            mst_r_valid_i = 1'b0;
   logic            mst_r_ready_i = 1'b1;
   logic            drain = 1'b0;
   logic            idle_o;
   logic [CntW-1:0] w_outstanding_o;
   logic [CntW-1:0] r_outstanding_o;

   always #5 clk = ~clk;

   axi_iw_txn_throttle #(
      .IdWidth(4), .MaxUniqIds(4), .MaxTxnsPerId(4), .MaxTxns(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .slv_aw_id_i(slv_aw_id_i), .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
      .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
      .mst_b_id_i(mst_b_id_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_i(mst_b_ready_i),
      .slv_ar_id_i(slv_ar_id_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
      .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
      .mst_r_id_i(mst_r_id_i), .mst_r_last_i(mst_r_last_i), .mst_r_valid_i(mst_r_valid_i),
      .mst_r_ready_i(mst_r_ready_i),
      .drain_i(drain), .idle_o(idle_o),
      .w_outstanding_o(w_outstanding_o), .r_outstanding_o(r_outstanding_o)
   );

   typedef struct {
      string nm;
      logic  aw_rdy;
      logic  aw_vld;
      logic  ar_rdy;
      logic  ar_vld;
      logic  idle;
      int    w;
      int    r;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   logic chk_en   = 1'b0;

   int wr_ret_ids [8] = '{0, 0, 1, 1, 1, 1, 5, 3};
   int rd_ret_ids [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

   // Monitor: compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         chk_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: got a sample with no expectation, want a queued entry");
         end else begin
            mon_e = exp_q.pop_front();
            if (slv_aw_ready_o === mon_e.aw_rdy && mst_aw_valid_o === mon_e.aw_vld &&
                slv_ar_ready_o === mon_e.ar_rdy && mst_ar_valid_o === mon_e.ar_vld &&
                idle_o === mon_e.idle &&
                w_outstanding_o === CntW'(mon_e.w) && r_outstanding_o === CntW'(mon_e.r)) begin
               pass_cnt++;
               $display("%0t %s ok: aw_rdy=%b aw_vld=%b ar_rdy=%b ar_vld=%b idle=%b w=%0d r=%0d",
                        $time, mon_e.nm, slv_aw_ready_o, mst_aw_valid_o, slv_ar_ready_o,
                        mst_ar_valid_o, idle_o, w_outstanding_o, r_outstanding_o);
            end else begin
               $display("FAIL %s: got aw_rdy=%b aw_vld=%b ar_rdy=%b ar_vld=%b idle=%b w=%0d r=%0d, want aw_rdy=%b aw_vld=%b ar_rdy=%b ar_vld=%b idle=%b w=%0d r=%0d",
                        mon_e.nm, slv_aw_ready_o, mst_aw_valid_o, slv_ar_ready_o, mst_ar_valid_o,
                        idle_o, w_outstanding_o, r_outstanding_o, mon_e.aw_rdy, mon_e.aw_vld,
                        mon_e.ar_rdy, mon_e.ar_vld, mon_e.idle, mon_e.w, mon_e.r);
            end
         end
      end
   end

   // Drive one cycle and queue the expected snapshot for that cycle.
   // e_awa/e_ara are the expected allow terms for the presented IDs.
   task automatic cyc(input string nm,
                      input logic awv, input int awid, input logic arv, input int arid,
                      input logic bv, input int bid, input logic rv, input int rid, input logic rl,
                      input logic e_awa, input logic e_ara, input logic e_idle,
                      input int e_w, input int e_r);
      exp_t e;
      slv_aw_valid_i = awv;  slv_aw_id_i = 4'(awid);
      slv_ar_valid_i = arv;  slv_ar_id_i = 4'(arid);
      mst_b_valid_i  = bv;   mst_b_id_i  = 4'(bid);
      mst_r_valid_i  = rv;   mst_r_id_i  = 4'(rid);  mst_r_last_i = rl;
      e.nm     = nm;
      e.aw_rdy = mst_aw_ready_i & e_awa;
      e.aw_vld = awv & e_awa;
      e.ar_rdy = mst_ar_ready_i & e_ara;
      e.ar_vld = arv & e_ara;
      e.idle   = e_idle;
      e.w      = e_w;
      e.r      = e_r;
      exp_q.push_back(e);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      cyc("reset", 0,0, 0,0, 0,0, 0,0,0, 1,1,0, 0,0);

      // Per-ID limit on ID 3
      for (int k = 0; k < 4; k++)
         cyc($sformatf("aw3_%0d", k), 1,3, 0,0, 0,0, 0,0,0, 1,1,0, k,0);
      cyc("aw3_5th_stall", 1,3, 0,0, 0,0, 0,0,0, 0,1,0, 4,0);
      cyc("aw3_stall_b3",  1,3, 0,0, 1,3, 0,0,0, 0,1,0, 4,0);
      cyc("aw3_after_b3",  1,3, 0,0, 0,0, 0,0,0, 1,1,0, 3,0);
      for (int k = 0; k < 4; k++)
         cyc($sformatf("b3_clean_%0d", k), 0,0, 0,0, 1,3, 0,0,0, 1,1,0, 4-k,0);

      // Distinct-ID limit and entry reuse
      for (int k = 0; k < 4; k++)
         cyc($sformatf("aw_id%0d", k), 1,k, 0,0, 0,0, 0,0,0, 1,1,0, k,0);
      cyc("aw5_no_entry",  1,5, 0,0, 0,0, 0,0,0, 0,1,0, 4,0);
      cyc("aw5_b2",        1,5, 0,0, 1,2, 0,0,0, 0,1,0, 4,0);
      cyc("aw5_reuse",     1,5, 0,0, 0,0, 0,0,0, 1,1,0, 3,0);

      // Same-cycle issue and retire on ID 1 keeps its count at 2
      cyc("aw1_cnt2",      1,1, 0,0, 0,0, 0,0,0, 1,1,0, 4,0);
      cyc("aw1_b1_same",   1,1, 0,0, 1,1, 0,0,0, 1,1,0, 5,0);
      cyc("aw1_cnt3",      1,1, 0,0, 0,0, 0,0,0, 1,1,0, 5,0);
      cyc("aw1_cnt4",      1,1, 0,0, 0,0, 0,0,0, 1,1,0, 6,0);
      cyc("aw1_full",      1,1, 0,0, 0,0, 0,0,0, 0,1,0, 7,0);
      mst_aw_ready_i = 1'b0;
      cyc("aw0_mst_busy",  1,0, 0,0, 0,0, 0,0,0, 1,1,0, 7,0);
      mst_aw_ready_i = 1'b1;
      cyc("aw0_tot7",      1,0, 0,0, 0,0, 0,0,0, 1,1,0, 7,0);
      cyc("aw0_tot_full",  1,0, 0,0, 0,0, 0,0,0, 0,1,0, 8,0);
      cyc("b9_unmatched",  0,0, 0,0, 1,9, 0,0,0, 0,1,0, 8,0);
      for (int k = 0; k < 8; k++)
         cyc($sformatf("b_clean_%0d", k), 0,0, 0,0, 1,wr_ret_ids[k], 0,0,0,
             (k != 0), 1, 0, 8-k, 0);
      cyc("b3_underflow",  0,0, 0,0, 1,3, 0,0,0, 1,1,0, 0,0);

      // Read total limit; only R with last retires
      for (int k = 0; k < 8; k++)
         cyc($sformatf("ar_id%0d", k % 4), 0,0, 1,k % 4, 0,0, 0,0,0, 1,1,0, 0,k);
      cyc("ar_9th_stall",  0,0, 1,0, 0,0, 0,0,0, 1,0,0, 0,8);
      cyc("r_no_last",     0,0, 1,0, 0,0, 1,0,0, 1,0,0, 0,8);
      cyc("r_last",        0,0, 1,0, 0,0, 1,0,1, 1,0,0, 0,8);
      cyc("ar_after_last", 0,0, 1,0, 0,0, 0,0,0, 1,1,0, 0,7);
      for (int k = 0; k < 8; k++)
         cyc($sformatf("r_clean_%0d", k), 0,0, 0,0, 0,0, 1,rd_ret_ids[k],1,
             1, (k != 0), 0, 0, 8-k);

      // Drain with 3 writes and 2 reads in flight
      cyc("d_aw0_ar4",     1,0, 1,4, 0,0, 0,0,0, 1,1,0, 0,0);
      cyc("d_aw1_ar5",     1,1, 1,5, 0,0, 0,0,0, 1,1,0, 1,1);
      cyc("d_aw2",         1,2, 0,0, 0,0, 0,0,0, 1,1,0, 2,2);
      drain = 1'b1;
      cyc("d_req",         0,0, 0,0, 0,0, 0,0,0, 1,1,0, 3,2);
      cyc("d_blk_b0",      1,0, 1,0, 1,0, 0,0,0, 0,0,0, 3,2);
      cyc("d_blk_b1",      1,0, 1,0, 1,1, 0,0,0, 0,0,0, 2,2);
      cyc("d_b2_r4",       1,0, 1,0, 1,2, 1,4,1, 0,0,0, 1,2);
      cyc("d_r5",          0,0, 0,0, 0,0, 1,5,1, 0,0,0, 0,1);
      cyc("d_empty",       0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0);
      cyc("d_idle",        0,0, 0,0, 0,0, 0,0,0, 0,0,1, 0,0);
      drain = 1'b0;
      cyc("d_release",     0,0, 0,0, 0,0, 0,0,0, 0,0,1, 0,0);
      cyc("d_run_aw0",     1,0, 0,0, 0,0, 0,0,0, 1,1,0, 0,0);

      // Drain dropped before empty returns to RUN
      drain = 1'b1;
      cyc("ab_req",        0,0, 0,0, 0,0, 0,0,0, 1,1,0, 1,0);
      drain = 1'b0;
      cyc("ab_in_drain",   0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1,0);
      cyc("ab_run",        0,0, 0,0, 0,0, 0,0,0, 1,1,0, 1,0);
      cyc("ab_b0",         0,0, 0,0, 1,0, 0,0,0, 1,1,0, 1,0);

      // Drain while already empty still spends one cycle in DRAIN
      drain = 1'b1;
      cyc("e_req",         0,0, 0,0, 0,0, 0,0,0, 1,1,0, 0,0);
      cyc("e_drain",       0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0);
      drain = 1'b0;
      cyc("e_idle",        0,0, 0,0, 0,0, 0,0,0, 0,0,1, 0,0);
      cyc("e_run",         0,0, 0,0, 0,0, 0,0,0, 1,1,0, 0,0);

      // Reset with 5 in flight
      cyc("r_aw0_ar0",     1,0, 1,0, 0,0, 0,0,0, 1,1,0, 0,0);
      cyc("r_aw1_ar1",     1,1, 1,1, 0,0, 0,0,0, 1,1,0, 1,1);
      cyc("r_aw2",         1,2, 0,0, 0,0, 0,0,0, 1,1,0, 2,2);
      cyc("r_pre_rst",     0,0, 0,0, 0,0, 0,0,0, 1,1,0, 3,2);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cyc("r_post_aw0",    1,0, 0,0, 0,0, 0,0,0, 1,1,0, 0,0);
      cyc("r_post_cnt",    0,0, 0,0, 0,0, 0,0,0, 1,1,0, 1,0);

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         chk_cnt++;
         $display("FAIL queue_empty: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
